reg_write_sched: RTL and testbench

- Write-port scheduler for the 8x8-bit register file, which has a single write port.
- Accepts writeback requests from two sources: the ALU result path and the data-memory load-return path.
- Queues the requests in program order in a small FIFO and issues at most one registered write per cycle (WRITE/INADDRESS/IN) into the register file.
- Raises BUSYWAIT so the CPU stalls before the queue can overflow, and optionally exports a pending-write mask for read-hazard stalls.

---
 rtl/reg_write_sched.sv | 130 +++++++++++++
 tb/tb_reg_write_sched.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_write_sched.sv
// reg_write_sched: write-port scheduler for the 8x8 register file.
// Merges ALU and load-return writebacks into an in-order FIFO and issues
// at most one registered write per cycle. BUSYWAIT holds off the CPU
// before a dual push could overflow the queue.
// Optional feature macro: REGSCHED_SCOREBOARD_EN (registered PEND_MASK of
// registers with a queued or issuing write; tied to zero when undefined).
module reg_write_sched #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                ALU_REQ,
  input  logic [AW-1:0]       ALU_ADDR,
  input  logic [DW-1:0]       ALU_DATA,
  input  logic                MEM_REQ,
  input  logic [AW-1:0]       MEM_ADDR,
  input  logic [DW-1:0]       MEM_DATA,
  output logic                RF_WRITE,
  output logic [AW-1:0]       RF_INADDRESS,
  output logic [DW-1:0]       RF_IN,
  output logic                BUSYWAIT,
  output logic [(1<<AW)-1:0]  PEND_MASK
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << AW;

  logic [CW-1:0]              count_q, count_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0][AW-1:0]   ent_addr_q, ent_addr_d;
  logic [DEPTH-1:0][DW-1:0]   ent_data_q, ent_data_d;
  logic                       rf_write_q, rf_write_d;
  logic [AW-1:0]              rf_addr_q, rf_addr_d;
  logic [DW-1:0]              rf_data_q, rf_data_d;

  logic          mem_push, alu_push, pop;
  logic [PW-1:0] alu_slot;

  // Stall once only one free slot remains, so 2 pushes + 1 pop always fit.
  assign BUSYWAIT = (count_q >= CW'(DEPTH - 1));
  assign mem_push = MEM_REQ & ~BUSYWAIT;
  assign alu_push = ALU_REQ & ~BUSYWAIT;
  assign pop      = (count_q != '0);

  // FIFO next state: load entry (older instruction) goes in before ALU entry.
  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    alu_slot   = wr_ptr_q + PW'(mem_push);
    if (mem_push) begin
      ent_addr_d[wr_ptr_q] = MEM_ADDR;
      ent_data_d[wr_ptr_q] = MEM_DATA;
    end
    if (alu_push) begin
      ent_addr_d[alu_slot] = ALU_ADDR;
      ent_data_d[alu_slot] = ALU_DATA;
    end
    wr_ptr_d = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  // Issue stage: head entry becomes a one-cycle write; address/data hold otherwise.
  always_comb begin
    rf_write_d = pop;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    if (pop) begin
      rf_addr_d = ent_addr_q[rd_ptr_q];
      rf_data_d = ent_data_q[rd_ptr_q];
    end
  end

  // State registers; reset flushes the queue and drops same-cycle requests.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ent_addr_q <= '0;
      ent_data_q <= '0;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign RF_WRITE     = rf_write_q;
  assign RF_INADDRESS = rf_addr_q;
  assign RF_IN        = rf_data_q;

`ifdef REGSCHED_SCOREBOARD_EN
  logic [NREG-1:0] pend_q, pend_d;
  logic [PW-1:0]   offs;

  // Mask of registers owned by valid entries after this edge, plus the issuing write.
  always_comb begin
    pend_d = '0;
    offs   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      offs = PW'(k) - rd_ptr_d;
      if ({1'b0, offs} < count_d) pend_d[ent_addr_d[k]] = 1'b1;
    end
    if (rf_write_d) pend_d[rf_addr_d] = 1'b1;
  end

  // Pending mask register, cleared with the queue.
  always_ff @(posedge CLOCK) begin
    if (RESET) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign PEND_MASK = pend_q;
`else
  assign PEND_MASK = '0;
`endif

endmodule

// File: tb/tb_reg_write_sched.sv
// Bench for reg_write_sched: cycle-by-cycle vector table plus a
// hold-until-accepted stream checked against an in-order expected queue.
module tb_reg_write_sched;
  logic       CLOCK = 1'b0;
  logic       RESET, ALU_REQ, MEM_REQ;
  logic [2:0] ALU_ADDR, MEM_ADDR, RF_INADDRESS;
  logic [7:0] ALU_DATA, MEM_DATA, RF_IN, PEND_MASK;
  logic       RF_WRITE, BUSYWAIT;

  int total = 0;
  int bad   = 0;

  reg_write_sched dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .ALU_REQ(ALU_REQ), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .RF_WRITE(RF_WRITE), .RF_INADDRESS(RF_INADDRESS), .RF_IN(RF_IN),
    .BUSYWAIT(BUSYWAIT), .PEND_MASK(PEND_MASK)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic       rst;
    logic       ar; logic [2:0] aa; logic [7:0] ad;
    logic       mr; logic [2:0] ma; logic [7:0] md;
    logic       ew; logic [2:0] ea; logic [7:0] ed;
    logic       eb; logic [7:0] ep;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst,
                     input logic ar, input logic [2:0] aa, input logic [7:0] ad,
                     input logic mr, input logic [2:0] ma, input logic [7:0] md,
                     input logic ew, input logic [2:0] ea, input logic [7:0] ed,
                     input logic eb, input logic [7:0] ep);
    vec_t v;
    v.rst = rst; v.ar = ar; v.aa = aa; v.ad = ad; v.mr = mr; v.ma = ma; v.md = md;
    v.ew = ew; v.ea = ea; v.ed = ed; v.eb = eb; v.ep = ep;
    vq.push_back(v);
  endtask

  task automatic idle(input logic ew, input logic [2:0] ea, input logic [7:0] ed,
                      input logic eb, input logic [7:0] ep);
    add(0, 0, 0, 0, 0, 0, 0, ew, ea, ed, eb, ep);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] expq[$];
    logic [15:0] e;
    int          sent, cyc;
    logic        busy_b, req_b;
    localparam int NP = 6;

    // reset held 2 cycles with a live ALU request
    add(1, 1, 7, 8'hFF, 0, 0, 0,       0, 0, 8'h00, 0, 8'h00);
    add(1, 1, 7, 8'hFF, 0, 0, 0,       0, 0, 8'h00, 0, 8'h00);
    idle(0, 0, 8'h00, 0, 8'h00);
    idle(0, 0, 8'h00, 0, 8'h00);
    // single ALU write, one-cycle issue
    add(0, 1, 3, 8'h5A, 0, 0, 0,       0, 0, 8'h00, 0, 8'h08);
    idle(1, 3, 8'h5A, 0, 8'h08);
    idle(0, 3, 8'h5A, 0, 8'h00);
    // same-cycle MEM+ALU to one register: MEM first
    add(0, 1, 2, 8'h22, 1, 2, 8'h11,   0, 3, 8'h5A, 0, 8'h04);
    idle(1, 2, 8'h11, 0, 8'h04);
    idle(1, 2, 8'h22, 0, 8'h04);
    idle(0, 2, 8'h22, 0, 8'h00);
    // both requesters every cycle; held requests retried after BUSYWAIT
    add(0, 1, 4, 8'hA2, 1, 1, 8'hA1,   0, 2, 8'h22, 0, 8'h12);
    add(0, 1, 6, 8'hB2, 1, 5, 8'hB1,   1, 1, 8'hA1, 1, 8'h72);
    add(0, 1, 7, 8'hC2, 1, 0, 8'hC1,   1, 4, 8'hA2, 0, 8'h70);
    add(0, 1, 7, 8'hC2, 1, 0, 8'hC1,   1, 5, 8'hB1, 1, 8'hE1);
    add(0, 1, 2, 8'hD2, 1, 3, 8'hD1,   1, 6, 8'hB2, 0, 8'hC1);
    add(0, 1, 2, 8'hD2, 1, 3, 8'hD1,   1, 0, 8'hC1, 1, 8'h8D);
    idle(1, 7, 8'hC2, 0, 8'h8C);
    idle(1, 3, 8'hD1, 0, 8'h0C);
    idle(1, 2, 8'hD2, 0, 8'h04);
    idle(0, 2, 8'hD2, 0, 8'h00);
    // fill 3 entries then reset: queue flushed, nothing issues
    add(0, 1, 2, 8'h32, 1, 1, 8'h31,   0, 2, 8'hD2, 0, 8'h06);
    add(0, 1, 4, 8'h34, 1, 3, 8'h33,   1, 1, 8'h31, 1, 8'h1E);
    add(1, 1, 5, 8'h35, 0, 0, 0,       0, 0, 8'h00, 0, 8'h00);
    idle(0, 0, 8'h00, 0, 8'h00);
    idle(0, 0, 8'h00, 0, 8'h00);

    RESET = 1'b1; ALU_REQ = 1'b0; MEM_REQ = 1'b0;
    ALU_ADDR = '0; ALU_DATA = '0; MEM_ADDR = '0; MEM_DATA = '0;

    for (int i = 0; i < vq.size(); i++) begin
      RESET = vq[i].rst;
      ALU_REQ = vq[i].ar; ALU_ADDR = vq[i].aa; ALU_DATA = vq[i].ad;
      MEM_REQ = vq[i].mr; MEM_ADDR = vq[i].ma; MEM_DATA = vq[i].md;
      @(posedge CLOCK); #1;
      chk($sformatf("row%0d RF_WRITE", i),     RF_WRITE,     vq[i].ew);
      chk($sformatf("row%0d RF_INADDRESS", i), RF_INADDRESS, vq[i].ea);
      chk($sformatf("row%0d RF_IN", i),        RF_IN,        vq[i].ed);
      chk($sformatf("row%0d BUSYWAIT", i),     BUSYWAIT,     vq[i].eb);
`ifdef REGSCHED_SCOREBOARD_EN
      chk($sformatf("row%0d PEND_MASK", i),    PEND_MASK,    vq[i].ep);
`else
      chk($sformatf("row%0d PEND_MASK", i),    PEND_MASK,    8'h00);
`endif
    end

    // stream of dual requests held until accepted; issues must match acceptance order
    sent = 0; cyc = 0;
    while ((sent < NP || expq.size() > 0) && cyc < 200) begin
      req_b = (sent < NP);
      MEM_REQ = req_b; MEM_ADDR = 3'(sent);     MEM_DATA = 8'h40 + 8'(sent);
      ALU_REQ = req_b; ALU_ADDR = 3'(sent + 3); ALU_DATA = 8'h80 + 8'(sent);
      busy_b = BUSYWAIT;
      @(posedge CLOCK); #1;
      cyc++;
      if (RF_WRITE) begin
        if (expq.size() == 0) chk("stream spurious write", RF_WRITE, 1'b0);
        else begin
          e = expq.pop_front();
          chk("stream addr", RF_INADDRESS, e[10:8]);
          chk("stream data", RF_IN, e[7:0]);
        end
      end
      if (req_b && !busy_b) begin
        expq.push_back({5'd0, MEM_ADDR, MEM_DATA});
        expq.push_back({5'd0, ALU_ADDR, ALU_DATA});
        sent++;
      end
    end
    MEM_REQ = 1'b0; ALU_REQ = 1'b0;
    chk("stream all sent", sent, NP);
    chk("stream drained", expq.size(), 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge CLOCK); #1;
      chk($sformatf("post drain RF_WRITE %0d", k), RF_WRITE, 1'b0);
      chk($sformatf("post drain BUSYWAIT %0d", k), BUSYWAIT, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
